// File: rtl/framebuffer_stream_writer.sv
// Streams framebuffer commit beats to memory as AXI4 INCR write bursts.
// Define FB_WRITER_4K_SPLIT_EN to keep every burst inside one 4 KiB page.
module framebuffer_stream_writer #(
  parameter int STREAM_WIDTH   = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int ID_WIDTH       = 8,
  parameter int MAX_BURST_LEN  = 16,
  parameter int BEAT_CNT_WIDTH = 20
) (
  input  logic                      aclk,
  input  logic                      reset,
  input  logic                      cmdStart,
  input  logic [ADDR_WIDTH-1:0]     cmdBaseAddr,
  input  logic [BEAT_CNT_WIDTH-1:0] cmdSizeInBeats,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  input  logic [STREAM_WIDTH-1:0]   s_axis_tdata,
  output logic [ID_WIDTH-1:0]       m_axi_awid,
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic [2:0]                m_axi_awsize,
  output logic [1:0]                m_axi_awburst,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [STREAM_WIDTH-1:0]   m_axi_wdata,
  output logic [STREAM_WIDTH/8-1:0] m_axi_wstrb,
  output logic                      m_axi_wlast,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [ID_WIDTH-1:0]       m_axi_bid,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready
);

  localparam int BYTES_PER_BEAT = STREAM_WIDTH / 8;
  localparam int SIZE_LOG2 = $clog2(BYTES_PER_BEAT);
  localparam logic [BEAT_CNT_WIDTH-1:0] MAX_REM =
    BEAT_CNT_WIDTH'(MAX_BURST_LEN);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DRAIN
  } state_t;

  state_t state, stateNext;

  logic [ADDR_WIDTH-1:0]     addr;
  logic [BEAT_CNT_WIDTH-1:0] remaining;
  logic [7:0]                burstLen;
  logic [7:0]                beatCnt;
  logic [3:0]                outstanding;
  logic [8:0]                burstBeats;
  logic                      awFire;
  logic                      wFire;
  logic                      bFire;
  logic                      lastBeat;
  logic                      startOk;
  logic                      unusedBid;

  assign unusedBid = ^m_axi_bid;

  always_comb begin
    burstBeats = (remaining > MAX_REM) ?
      9'(MAX_BURST_LEN) : 9'(remaining);
`ifdef FB_WRITER_4K_SPLIT_EN
    begin
      logic [12:0] toPage;
      toPage = (13'd4096 - {1'b0, addr[11:0]}) >> SIZE_LOG2;
      if (toPage < {4'd0, burstBeats})
        burstBeats = toPage[8:0];
    end
`endif
  end

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = addr;
  assign m_axi_awlen   = (state == ADDR) ?
    8'(burstBeats - 9'd1) : 8'd0;
  assign m_axi_awsize  = 3'(SIZE_LOG2);
  assign m_axi_awburst = 2'b01;
  // Stall new bursts once eight are waiting on a response.
  assign m_axi_awvalid = (state == ADDR) && !outstanding[3];

  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = (state == DATA) && s_axis_tvalid;
  assign s_axis_tready = (state == DATA) && m_axi_wready;
  assign m_axi_wlast   = (state == DATA) && (beatCnt == burstLen);
  assign m_axi_bready  = 1'b1;

  assign startOk  = (state == IDLE) && cmdStart;
  assign awFire   = m_axi_awvalid && m_axi_awready;
  assign wFire    = m_axi_wvalid && m_axi_wready;
  // Stray responses after a reset must not underflow the counter.
  assign bFire    = m_axi_bvalid && (outstanding != 4'd0);
  assign lastBeat = wFire && m_axi_wlast;

  always_ff @(posedge aclk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (cmdStart)
          stateNext = (cmdSizeInBeats == '0) ? DRAIN : ADDR;
      end
      ADDR: begin
        if (awFire) stateNext = DATA;
      end
      DATA: begin
        if (lastBeat)
          stateNext = (remaining != '0) ? ADDR : DRAIN;
      end
      DRAIN: begin
        if (outstanding == 4'd0) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      addr        <= '0;
      remaining   <= '0;
      burstLen    <= '0;
      beatCnt     <= '0;
      outstanding <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (startOk) begin
        addr      <= cmdBaseAddr;
        remaining <= cmdSizeInBeats;
        error     <= 1'b0;
        busy      <= 1'b1;
      end
      if (awFire) begin
        burstLen  <= 8'(burstBeats - 9'd1);
        beatCnt   <= '0;
        addr      <= addr + (ADDR_WIDTH'(burstBeats) << SIZE_LOG2);
        remaining <= remaining - BEAT_CNT_WIDTH'(burstBeats);
      end
      if (wFire) begin
        beatCnt <= beatCnt + 8'd1;
        // tlast must mark exactly the overall final beat.
        if (s_axis_tlast != (lastBeat && remaining == '0))
          error <= 1'b1;
      end
      if (bFire && m_axi_bresp != 2'b00)
        error <= 1'b1;
      unique case ({awFire, bFire})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase
      if (state == DRAIN && outstanding == 4'd0) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

endmodule
